// File: rtl/uart_transmitter.sv
// uart_transmitter: REQ/ACK byte intake, 8N1 serial output; define UART_TX_PARITY_EN for an even-parity bit
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       XMIT_REQ,
  input  logic [7:0] XMIT_DATA,
  output logic       XMIT_ACK,
  output logic       XMIT,
  output logic       XMIT_BUSY
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic xmit_n, ack_n, busy_n, req_q, tick, accept;
  // next-state, bit sequencing and handshake; an accept on the stop-bit boundary gives back-to-back frames
  always_comb begin
    tick = cnt == CW'(CLKS_PER_BIT - 1);
    accept = XMIT_REQ && !XMIT_ACK && (state == IDLE || (state == STOP && tick));
    state_n = state;
    cnt_n = (state == IDLE || tick) ? '0 : cnt + CW'(1);
    idx_n = idx;
    sh_n = sh;
    xmit_n = XMIT;
    busy_n = XMIT_BUSY;
    ack_n = req_q ? XMIT_ACK : 1'b0;
    case (state)
      START: if (tick) begin
        state_n = DATA;
        xmit_n = sh[0];
        idx_n = '0;
      end
      DATA: if (tick) begin
        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          xmit_n = ^sh;
`else
          state_n = STOP;
          xmit_n = 1'b1;
`endif
        end else begin
          idx_n = idx + 3'd1;
          xmit_n = sh[idx + 3'd1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_n = STOP;
        xmit_n = 1'b1;
      end
`endif
      STOP: if (tick) begin
        state_n = IDLE;
        busy_n = 1'b0;
      end
      default: ;
    endcase
    if (accept) begin
      state_n = START;
      cnt_n = '0;
      idx_n = '0;
      sh_n = XMIT_DATA;
      xmit_n = 1'b0;
      ack_n = 1'b1;
      busy_n = 1'b1;
    end
  end
  // state and registered outputs; clr wins over everything
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      XMIT <= 1'b1;
      XMIT_ACK <= 1'b0;
      XMIT_BUSY <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      XMIT <= xmit_n;
      XMIT_ACK <= ack_n;
      XMIT_BUSY <= busy_n;
      req_q <= XMIT_REQ;
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed and random frames checked cycle by cycle against a line model
module tb_uart_transmitter;
  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0, clr = 1, req = 0;
  logic [7:0] data = 0;
  logic ack, xmit, busy;
  int total = 0, bad = 0;

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .clr(clr), .XMIT_REQ(req), .XMIT_DATA(data),
    .XMIT_ACK(ack), .XMIT(xmit), .XMIT_BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && NB == 11) return ^d;
    return 1'b1;
  endfunction

  // d: byte; h: edges REQ stays high after accept; chain: raise REQ with nd mid-frame
  task automatic frame(input logic [7:0] d, input int h, input bit chain,
                       input logic [7:0] nd, input bit accepted);
    if (!accepted) begin
      req = 1;
      data = d;
      tick();
    end
    for (int i = 0; i < NB * C; i++) begin
      chk("line", xmit, line_bit(d, i / C));
      chk("busy", busy, 1'b1);
      chk("ack", ack, i <= h);
      if (i == h - 1) req = 0;
      if (!req) data = 8'($urandom);
      if (chain && i == 20) begin
        req = 1;
        data = nd;
      end
      tick();
    end
    chk("end_line", xmit, !chain);
    chk("end_busy", busy, chain);
    chk("end_ack", ack, chain || NB * C <= h);
  endtask

  initial begin
    logic [7:0] a, b;
    req = 1;
    data = 8'hA5;
    tick();
    tick();
    chk("rst_line", xmit, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    clr = 0;
    req = 0;
    repeat (3) begin
      tick();
      chk("idle_line", xmit, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end
    frame(8'hA5, 1, 0, 8'h00, 0);
    frame(8'h3C, 300, 0, 8'h00, 0);
    for (int j = NB * C + 1; j <= 300; j++) begin
      tick();
      chk("hold_line", xmit, 1'b1);
      chk("hold_busy", busy, 1'b0);
      chk("hold_ack", ack, 1'b1);
    end
    req = 0;
    tick();
    chk("ack_late", ack, 1'b1);
    tick();
    chk("ack_drop", ack, 1'b0);
    frame(8'h00, 1, 1, 8'hFF, 0);
    frame(8'hFF, 1, 0, 8'h00, 1);
    frame(8'h81, 1, 0, 8'h00, 0);
    frame(8'h07, 1, 0, 8'h00, 0);
    frame(8'h03, 1, 0, 8'h00, 0);
    repeat (8) begin
      frame(8'($urandom), $urandom_range(1, 60), 0, 8'h00, 0);
      repeat ($urandom_range(0, 5)) tick();
    end
    repeat (3) begin
      a = 8'($urandom);
      b = 8'($urandom);
      frame(a, $urandom_range(1, 15), 1, b, 0);
      frame(b, $urandom_range(1, 15), 0, 8'h00, 1);
    end
    req = 1;
    data = 8'h55;
    tick();
    for (int i = 0; i < 45; i++) begin
      chk("pre_clr_line", xmit, line_bit(8'h55, i / C));
      if (i == 0) req = 0;
      tick();
    end
    clr = 1;
    tick();
    clr = 0;
    chk("clr_line", xmit, 1'b1);
    chk("clr_ack", ack, 1'b0);
    chk("clr_busy", busy, 1'b0);
    repeat (20) begin
      tick();
      chk("post_clr_line", xmit, 1'b1);
      chk("post_clr_busy", busy, 1'b0);
    end
    a = 8'($urandom);
    req = 1;
    data = 8'hC3;
    tick();
    repeat (30) tick();
    clr = 1;
    data = a;
    tick();
    clr = 0;
    chk("clr2_line", xmit, 1'b1);
    chk("clr2_ack", ack, 1'b0);
    chk("clr2_busy", busy, 1'b0);
    tick();
    frame(a, 1, 0, 8'h00, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
